ocimem_debug_access_engine: RTL

- Sysclk-domain stage directly downstream of the debug-slave wrapper: consumes jdo and the ocimem take-action strobes and performs the requested access on the on-chip debug RAM (OCI RAM).
- Returns read data on MonDReg and status on monitor_ready/monitor_error, which feed back into the wrapper's TCK-side capture path.
- Arbitrates against CPU-side RAM accesses (CPU always wins) and auto-increments the debug address for burst download/upload.

---
 rtl/ocimem_debug_access_engine.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/ocimem_debug_access_engine.sv
// OCI debug RAM access engine: services ocimem take-action strobes from the debug
// slave wrapper, arbitrates against the CPU and returns read data/status.
//
// state | meaning
// IDLE  | waiting for a strobe; address-only loads complete here
// ARB   | waiting for CPU to release the RAM, then issue one rd/wr strobe
// RWAIT | counting RAM read latency, capture read data into MonDReg
// DONE  | optional address increment, report ready
module ocimem_debug_access_engine #(
  parameter int ADDR_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  input  logic              cpu_ram_req,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wrdata,
  output logic              ram_wr,
  output logic              ram_rd,
  input  logic [31:0]       ram_rddata,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error,
  output logic              busy
);

  localparam int CNT_W = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARB   = 2'd1,
    RWAIT = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic               op_wr_q, op_wr_d;
  logic               inc_q, inc_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [ADDR_W-1:0]  ram_addr_q, ram_addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [31:0]        mon_q, mon_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               issue;
  logic               any_stb, multi_stb;
  logic [ADDR_W-1:0]  jdo_addr;
  logic               jdo_unused;

  assign jdo_addr   = jdo[ADDR_W+16:17];
  assign jdo_unused = ^{jdo[37:36], jdo[2:0]};
  assign any_stb    = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
  assign multi_stb  = (take_action_ocimem_a & take_action_ocimem_b) |
                      (take_action_ocimem_a & take_no_action_ocimem_a) |
                      (take_action_ocimem_b & take_no_action_ocimem_a);

  always_comb begin
    state_d    = state_q;
    op_wr_d    = op_wr_q;
    inc_d      = inc_q;
    addr_d     = addr_q;
    ram_addr_d = ram_addr_q;
    wdata_d    = wdata_q;
    mon_d      = mon_q;
    err_d      = err_q;
    cnt_d      = cnt_q;
    issue      = 1'b0;
    case (state_q)
      IDLE: begin
        if (multi_stb) err_d = 1'b1;
        if (take_action_ocimem_a) begin
          addr_d = jdo_addr;
          if (jdo[14]) begin
            op_wr_d = 1'b0;
            inc_d   = 1'b0;
            state_d = ARB;
          end
          // clear wins over a same-cycle drop of the lower-priority strobes
          if (jdo[35]) err_d = 1'b0;
        end else if (take_action_ocimem_b) begin
          wdata_d = jdo[34:3];
          op_wr_d = 1'b1;
          inc_d   = 1'b1;
          state_d = ARB;
        end else if (take_no_action_ocimem_a) begin
          op_wr_d = 1'b0;
          inc_d   = 1'b1;
          state_d = ARB;
        end
      end
      ARB: begin
        if (any_stb) err_d = 1'b1;
        if (!cpu_ram_req) begin
          issue      = 1'b1;
          ram_addr_d = addr_q;
          cnt_d      = CNT_W'(RD_LAT - 1);
          state_d    = op_wr_q ? DONE : RWAIT;
        end
      end
      RWAIT: begin
        if (any_stb) err_d = 1'b1;
        if (cnt_q == '0) begin
          mon_d   = ram_rddata;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        if (any_stb) err_d = 1'b1;
        if (inc_q) addr_d = addr_q + ADDR_W'(1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      op_wr_q    <= 1'b0;
      inc_q      <= 1'b0;
      addr_q     <= '0;
      ram_addr_q <= '0;
      wdata_q    <= '0;
      mon_q      <= '0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      op_wr_q    <= op_wr_d;
      inc_q      <= inc_d;
      addr_q     <= addr_d;
      ram_addr_q <= ram_addr_d;
      wdata_q    <= wdata_d;
      mon_q      <= mon_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
    end
  end

  // RAM strobes are combinational so the access lands in the first free ARB cycle
  assign ram_wr        = issue & op_wr_q & ~reset;
  assign ram_rd        = issue & ~op_wr_q & ~reset;
  assign ram_addr      = (issue && !reset) ? addr_q : ram_addr_q;
  assign ram_wrdata    = wdata_q;
  assign MonDReg       = mon_q;
  assign monitor_error = err_q;
  assign busy          = (state_q != IDLE);
  assign monitor_ready = (state_q == IDLE);

endmodule
